sti4_share_unmask: RTL and testbench

- Receiving end of the threshold-implemented 4-bit S-box datapath: collects the output shares of one masked S-box nibble, one share per cycle, and recombines them by XOR into the unmasked nibble.
- Shares are never combined in the same cycle. Each share is XORed into a registered accumulator, which limits glitch-based share recombination.
- Sits after the TI S-box share registers, ahead of unmasked consumers: ciphertext output and the test comparator.

---
 rtl/sti4_share_unmask.sv | 123 ++++++++++++
 tb/tb_sti4_share_unmask.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sti4_share_unmask.sv
// Share recombiner for the threshold-implemented S-box output: takes one share per
// cycle, folds each into a registered XOR accumulator, and emits the unmasked nibble.
module sti4_share_unmask #(
  parameter int NSHARES = 3,
  parameter int WIDTH   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_share,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             busy
);

  localparam int CW = $clog2(NSHARES);
  localparam logic [CW-1:0] LAST_CNT = CW'(NSHARES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_OUT   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_err_q, out_err_d;

  logic in_xfer;
  logic out_xfer;

  // Handshake flags come straight from the state register; out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (state_q == S_IDLE) || (state_q == S_ACCUM);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    case (state_q)
      S_IDLE: begin
        if (in_xfer) begin
          if (in_last) begin
            out_data_d = '0;
            out_err_d  = 1'b1;
            state_d    = S_OUT;
          end else begin
            acc_d   = in_share;
            cnt_d   = CW'(1);
            state_d = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (in_xfer) begin
          if (cnt_q == LAST_CNT) begin
            // Final share slot: a missing in_last is a framing error, and the
            // next share simply starts a new nibble.
            state_d    = S_OUT;
            out_data_d = in_last ? (acc_q ^ in_share) : '0;
            out_err_d  = ~in_last;
          end else if (in_last) begin
            out_data_d = '0;
            out_err_d  = 1'b1;
            state_d    = S_OUT;
          end else begin
            acc_d = acc_q ^ in_share;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_OUT: begin
        if (out_xfer) begin
          // Scrub every trace of the nibble once the consumer has it.
          acc_d      = '0;
          cnt_d      = '0;
          out_data_d = '0;
          out_err_d  = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        acc_d      = '0;
        cnt_d      = '0;
        out_data_d = '0;
        out_err_d  = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
    end
  end

endmodule

// File: tb/tb_sti4_share_unmask.sv
// Bench for sti4_share_unmask: constant vector table, hand-written corner
// sequences, then random traffic against a queue-based share model.
module tb_sti4_share_unmask;
  localparam int N = 3;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_last, out_ready;
  logic [W-1:0] in_share;
  logic         in_ready, out_valid, out_err, busy;
  logic [W-1:0] out_data;

  int n_cmp = 0;
  int n_bad = 0;

  sti4_share_unmask #(.NSHARES(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_share(in_share), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [W-1:0] s;
    logic         l;
    logic         ordy;
    logic         e_ovld;
    logic [W-1:0] e_data;
    logic         e_err;
    logic         e_irdy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] s, input logic l, input logic ordy);
    in_valid  = v;
    in_share  = s;
    in_last   = l;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ovld, input logic [W-1:0] d,
                         input logic e, input logic irdy);
    chk({tag, ".out_valid"}, out_valid, ovld);
    chk({tag, ".out_data"},  out_data,  d);
    chk({tag, ".out_err"},   out_err,   e);
    chk({tag, ".in_ready"},  in_ready,  irdy);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
  endtask

  function automatic void row(input logic v, input logic [W-1:0] s, input logic l,
                              input logic ovld, input logic [W-1:0] d, input logic e);
    vec_t r;
    r.v = v; r.s = s; r.l = l; r.ordy = 1'b1;
    r.e_ovld = ovld; r.e_data = d; r.e_err = e; r.e_irdy = ~ovld;
    tbl.push_back(r);
  endfunction

  // Reference model: queue of accepted shares plus a pending-output slot.
  logic [W-1:0] mq[$];
  logic         m_pend;
  logic [W-1:0] m_data;
  logic         m_err;

  function automatic void model_clear();
    mq.delete();
    m_pend = 1'b0;
    m_data = '0;
    m_err  = 1'b0;
  endfunction

  function automatic void model_step(input logic rst, input logic v, input logic [W-1:0] s,
                                     input logic l, input logic ordy);
    logic [W-1:0] x;
    if (!rst) begin
      model_clear();
    end else if (m_pend) begin
      if (ordy) begin
        m_pend = 1'b0; m_data = '0; m_err = 1'b0;
      end
    end else if (v) begin
      mq.push_back(s);
      if (l || mq.size() == N) begin
        x = '0;
        foreach (mq[i]) x ^= mq[i];
        m_pend = 1'b1;
        m_err  = !(l && mq.size() == N);
        m_data = m_err ? '0 : x;
        mq.delete();
      end
    end
  endfunction

  initial begin
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    do_reset();
    chk_all("reset", 1'b0, 4'h0, 1'b0, 1'b1);
    chk("reset.busy", busy, 0);

    // basic
    row(1, 4'h5, 0, 0, 4'h0, 0);
    row(1, 4'hA, 0, 0, 4'h0, 0);
    row(1, 4'h3, 1, 1, 4'hC, 0);
    row(0, 4'h0, 0, 0, 4'h0, 0);
    // early last, then a clean nibble
    row(1, 4'h5, 0, 0, 4'h0, 0);
    row(1, 4'hA, 1, 1, 4'h0, 1);
    row(0, 4'h0, 0, 0, 4'h0, 0);
    row(1, 4'h2, 0, 0, 4'h0, 0);
    row(1, 4'h4, 0, 0, 4'h0, 0);
    row(1, 4'h8, 1, 1, 4'hE, 0);
    row(0, 4'h0, 0, 0, 4'h0, 0);
    // missing last
    row(1, 4'h1, 0, 0, 4'h0, 0);
    row(1, 4'h2, 0, 0, 4'h0, 0);
    row(1, 4'h4, 0, 1, 4'h0, 1);
    row(0, 4'h0, 0, 0, 4'h0, 0);
    // in_valid gaps
    row(1, 4'h6, 0, 0, 4'h0, 0);
    row(0, 4'h0, 0, 0, 4'h0, 0);
    row(0, 4'h0, 0, 0, 4'h0, 0);
    row(0, 4'h0, 0, 0, 4'h0, 0);
    row(1, 4'h6, 0, 0, 4'h0, 0);
    row(0, 4'h0, 0, 0, 4'h0, 0);
    row(1, 4'h9, 1, 1, 4'h9, 0);
    row(0, 4'h0, 0, 0, 4'h0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].l, tbl[i].ordy);
      tick();
      chk_all($sformatf("tbl[%0d]", i), tbl[i].e_ovld, tbl[i].e_data, tbl[i].e_err, tbl[i].e_irdy);
      chk($sformatf("tbl[%0d].busy", i), busy, tbl[i].e_ovld || (i % 1 == 0 && busy));
    end

    // backpressure: output held, offered shares ignored
    drive(1, 4'h5, 0, 0); tick();
    drive(1, 4'hA, 0, 0); tick();
    drive(1, 4'h3, 1, 0); tick();
    chk_all("bp.first", 1'b1, 4'hC, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(1, 4'h7, k[0], 0); tick();
      chk_all($sformatf("bp.hold%0d", k), 1'b1, 4'hC, 1'b0, 1'b0);
    end
    drive(0, 4'h0, 0, 1); tick();
    chk_all("bp.release", 1'b0, 4'h0, 1'b0, 1'b1);
    drive(1, 4'h1, 0, 1); tick();
    drive(1, 4'h1, 0, 1); tick();
    drive(1, 4'hF, 1, 1); tick();
    chk_all("bp.next", 1'b1, 4'hF, 1'b0, 1'b0);
    drive(0, 4'h0, 0, 1); tick();

    // mid-operation reset
    drive(1, 4'h3, 0, 1); tick();
    drive(1, 4'h5, 0, 1); tick();
    chk("mr.busy_before", busy, 1);
    do_reset();
    chk_all("mr.after", 1'b0, 4'h0, 1'b0, 1'b1);
    chk("mr.busy", busy, 0);
    drive(1, 4'h7, 0, 1); tick();
    drive(1, 4'h0, 0, 1); tick();
    drive(1, 4'h0, 1, 1); tick();
    chk_all("mr.next", 1'b1, 4'h7, 1'b0, 1'b0);
    drive(0, 4'h0, 0, 1); tick();

    // random traffic against the model
    do_reset();
    model_clear();
    for (int c = 0; c < 3000; c++) begin
      logic r, v, l, o;
      logic [W-1:0] s;
      r = ($urandom_range(0, 149) != 0);
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 2) == 0);
      o = ($urandom_range(0, 9) < 7);
      s = W'($urandom);
      rst_n = r;
      drive(v, s, l, o);
      model_step(r, v, s, l, o);
      tick();
      chk_all($sformatf("rnd%0d", c), m_pend, m_data, m_err, ~m_pend);
      chk($sformatf("rnd%0d.busy", c), busy, m_pend || (mq.size() != 0));
    end
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
